mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the core's single memory port. Shares the port between instruction fetch (read-only) and the load/store unit (read/write) with round-robin priority, one outstanding transaction at a time. Drives the 2-bit select of the 3-way address/control multiplexer in front of memory, and enforces a bus timeout that reports an error.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- TIMEOUT, 16, max cycles m_req may stay high without m_ready; 0 disables the timeout
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; hold with i_addr stable until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle accept pulse to fetch
- i_rvalid  out  1  one-cycle completion pulse to fetch
- i_rdata  out  DW  fetch data, valid with i_rvalid
- i_err  out  1  timeout flag, valid with i_rvalid
- d_req  in  1  data request; hold with d_we, d_be, d_addr, d_wdata stable until d_gnt
- d_we  in  1  1 = write
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DW/1  as for the i_ side
- m_req  out  1  memory request, held until m_ready or timeout
- m_we, m_be, m_addr, m_wdata  out  1/DW/8/AW/DW  captured transaction fields
- m_ready  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DW  memory read data
- mem_sel  out  2  mux select: 2'b00 fetch, 2'b01 data, 2'b10 idle; 2'b11 never driven

## Operation
- States: IDLE, BUSY. Register last_owner (I or D); it resets to D, so fetch wins the first tie.
- IDLE, sampled at the clock edge:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_owner.
  - Neither high: stay in IDLE.
- On grant:
  - Capture the owner's fields into the m_* registers. Fetch grants force m_we=0, m_be=all ones, m_wdata=0.
  - Set owner and last_owner.
  - Go to BUSY and clear the timeout counter.
- BUSY:
  - m_req=1 and mem_sel=owner code.
  - The owner's gnt pulses high for exactly the first BUSY cycle.
  - Both req inputs are ignored.
- Completion: when m_ready=1 in BUSY:
  - Register m_rdata into the owner's rdata, pulse the owner's rvalid with err=0, return to IDLE.
  - Writes also produce the rvalid pulse; rdata carries m_rdata unmodified.
- Timeout (TIMEOUT>0): the counter increments on every BUSY cycle with m_ready=0. When it reaches TIMEOUT, drop m_req, pulse the owner's rvalid with err=1 and rdata=0, and return to IDLE.
  - If m_ready arrives in that same cycle, completion wins and err=0.
- Non-owner gnt, rvalid and err stay 0 throughout.
- A requester whose req is still high when the arbiter re-enters IDLE is treated as a new request. Requesters drop req after seeing gnt unless they are issuing another access.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE and last_owner to D.
  - Outputs take these values: m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, mem_sel=2'b10, all gnt/rvalid/err=0, both rdata=0.
  - The in-flight transaction is dropped with no rvalid.
- mem_sel and all m_* outputs come from registers; no combinational path from inputs to outputs.

## Timing
- Request sampled at edge N → BUSY from cycle N+1: gnt pulse, m_req=1 and mem_sel valid all in cycle N+1.
- m_ready high in cycle M → rvalid/rdata in cycle M+1, state IDLE in M+1.
- The next grant is sampled at edge M+1 at the earliest, so its m_req starts in cycle M+2.
- Zero-wait memory (m_ready in N+1) gives a request-to-rvalid latency of 2 cycles and a throughput of one access per 2 cycles.
- Timeout: m_req is high for exactly TIMEOUT cycles; the err pulse appears the cycle after the last of them.
- m_* outputs are stable for the whole time m_req is high.

## Test plan
- Reset during BUSY (m_req=1, owner D): immediately m_req=0, mem_sel=2'b10, no d_rvalid; after release, an idle cycle keeps all outputs at their reset values.
- Single fetch, i_addr=0x0000_0100, m_ready on the first BUSY cycle with m_rdata=0x0000_0013: i_gnt in N+1, mem_sel=2'b00, m_addr=0x100, m_we=0; i_rvalid=1, i_rdata=0x13, i_err=0 in N+2.
- Data write, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011, 3 wait cycles: mem_sel=2'b01, m_* stable for 4 cycles, then a single d_rvalid pulse with d_err=0.
- i_req and d_req held high continuously from reset: grant order I, D, I, D; gnt pulses never overlap; mem_sel alternates 2'b00/2'b01 with 2'b10 between accesses.
- TIMEOUT=16, m_ready tied low, data read: m_req high for 16 cycles, then d_rvalid=1, d_err=1, d_rdata=0; the arbiter then grants a pending i_req.
- m_ready rises in the same cycle the timeout expires: completion is reported with err=0 and rdata=m_rdata.

Source files
------------

// File: rtl/mem_port_if.sv
// Bundle of requester, memory and mux-select signals around the memory port arbiter.
// slave: the arbiter's view. master: the requesters and the memory seen from outside.
interface mem_port_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Instruction fetch side
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  // Load/store side
  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_err;

  // Memory side
  logic            m_req;
  logic            m_we;
  logic [DW/8-1:0] m_be;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      mem_sel;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  m_ready, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_we, m_be, m_addr, m_wdata, mem_sel
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output m_ready, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_we, m_be, m_addr, m_wdata, mem_sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for the single memory port.
// One transaction in flight; all outputs are registered. A bus timeout ends a stuck
// transaction with an error completion.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  mem_port_if.slave bus
);

  localparam int unsigned BW        = DW / 8;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam int unsigned CW        = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last BUSY cycle m_req may stay high
  localparam logic [CW-1:0] CntLast = TimeoutEn ? CW'(TIMEOUT - 1) : '0;

  localparam logic       OwnI    = 1'b0;
  localparam logic       OwnD    = 1'b1;
  localparam logic [1:0] SelIdle = 2'b10;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [BW-1:0]   m_be_q, m_be_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [1:0]      mem_sel_q, mem_sel_d;
  logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic            i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            pick;
  logic            done;
  logic            err;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, capture, completion and timeout decisions
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    mem_sel_d  = mem_sel_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_err_d    = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick       = OwnI;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie the requester that did not own the port last time wins
          if (bus.i_req && bus.d_req) begin
            pick = ~last_q;
          end else begin
            pick = bus.d_req ? OwnD : OwnI;
          end
          state_d   = StBusy;
          owner_d   = pick;
          last_d    = pick;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          mem_sel_d = {1'b0, pick};
          if (pick == OwnD) begin
            m_we_d    = bus.d_we;
            m_be_d    = bus.d_be;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            d_gnt_d   = 1'b1;
          end else begin
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
            i_gnt_d   = 1'b1;
          end
        end
      end
      StBusy: begin
        // Completion takes precedence over a timeout expiring in the same cycle
        if (bus.m_ready) begin
          done = 1'b1;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          state_d   = StIdle;
          m_req_d   = 1'b0;
          mem_sel_d = SelIdle;
          if (owner_q == OwnD) begin
            d_rvalid_d = 1'b1;
            d_err_d    = err;
            d_rdata_d  = err ? '0 : bus.m_rdata;
          end else begin
            i_rvalid_d = 1'b1;
            i_err_d    = err;
            i_rdata_d  = err ? '0 : bus.m_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OwnI;
      last_q     <= OwnD;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      mem_sel_q  <= SelIdle;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      mem_sel_q  <= mem_sel_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_gnt    = i_gnt_q;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_err    = i_err_q;
  assign bus.d_gnt    = d_gnt_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.mem_sel  = mem_sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset cases, a table of single accesses,
// hand-written round-robin and timeout sequences, and a randomized run against a
// transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;       // m_req cycles before the one carrying m_ready
    logic [31:0] mrdata;
    logic [1:0]  x_sel;
    bit          x_we;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    int          x_mcycles;
    bit          x_err;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/m_req"}, bus.m_req, 0);
    check({tag, "/m_we"}, bus.m_we, 0);
    check({tag, "/m_be"}, bus.m_be, 0);
    check({tag, "/m_addr"}, bus.m_addr, 0);
    check({tag, "/m_wdata"}, bus.m_wdata, 0);
    check({tag, "/mem_sel"}, bus.mem_sel, 2'b10);
    check({tag, "/gnt"}, {bus.i_gnt, bus.d_gnt}, 0);
    check({tag, "/rvalid"}, {bus.i_rvalid, bus.d_rvalid}, 0);
    check({tag, "/err"}, {bus.i_err, bus.d_err}, 0);
    check({tag, "/i_rdata"}, bus.i_rdata, 0);
    check({tag, "/d_rdata"}, bus.d_rdata, 0);
  endtask

  // One access from an idle arbiter, with a fixed memory latency
  task automatic run_vec(input vec_t v, input int idx);
    int    mc;
    string t;
    t = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_be    = v.be;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.i_req   = 1'b1;
      bus.i_addr  = v.addr;
      // Junk on the idle data side must not leak into a fetch
      bus.d_we    = 1'b1;
      bus.d_be    = 4'h5;
      bus.d_wdata = 32'hFFFF_0000;
    end
    step();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    mc = 0;
    while (bus.m_req === 1'b1 && mc < 40) begin
      mc++;
      check({t, "/i_gnt"}, bus.i_gnt, (mc == 1) && !v.is_d);
      check({t, "/d_gnt"}, bus.d_gnt, (mc == 1) && v.is_d);
      check({t, "/mem_sel"}, bus.mem_sel, v.x_sel);
      check({t, "/m_addr"}, bus.m_addr, v.addr);
      check({t, "/m_we"}, bus.m_we, v.x_we);
      check({t, "/m_be"}, bus.m_be, v.x_be);
      check({t, "/m_wdata"}, bus.m_wdata, v.x_wdata);
      bus.m_ready = (mc == v.lat + 1);
      bus.m_rdata = bus.m_ready ? v.mrdata : $urandom;
      step();
    end
    bus.m_ready = 1'b0;
    check({t, "/m_req_cycles"}, mc, v.x_mcycles);
    check({t, "/i_rvalid"}, bus.i_rvalid, !v.is_d);
    check({t, "/d_rvalid"}, bus.d_rvalid, v.is_d);
    check({t, "/err"}, v.is_d ? bus.d_err : bus.i_err, v.x_err);
    check({t, "/rdata"}, v.is_d ? bus.d_rdata : bus.i_rdata, v.x_rdata);
    check({t, "/sel_idle"}, bus.mem_sel, 2'b10);
    step();
    check({t, "/rvalid_single"}, {bus.i_rvalid, bus.d_rvalid}, 0);
  endtask

  // Randomized traffic checked against a transaction-level model of the arbitration rules
  task automatic run_random(input int ncycles);
    bit          pend[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_be[2];
    bit          p_we[2];
    bit          busy = 1'b0;
    bit          busy_next;
    int          own = 0;
    int          last = 1;
    int          mcyc = 0;
    int          lat = 0;
    int          x_gnt = -1;
    int          x_rv = -1;
    bit          x_err = 1'b0;
    logic [31:0] x_rdata = '0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  t_be = '0;
    bit          t_we = 1'b0;
    bit          ready;
    logic [31:0] mdata;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0;
      p_addr[r] = '0;
      p_wdata[r] = '0;
      p_be[r] = '0;
      p_we[r] = 1'b0;
    end
    for (int c = 0; c < ncycles; c++) begin
      step();
      check("rnd/i_gnt", bus.i_gnt, x_gnt == 0);
      check("rnd/d_gnt", bus.d_gnt, x_gnt == 1);
      check("rnd/i_rvalid", bus.i_rvalid, x_rv == 0);
      check("rnd/d_rvalid", bus.d_rvalid, x_rv == 1);
      if (x_rv == 0) begin
        check("rnd/i_err", bus.i_err, x_err);
        check("rnd/i_rdata", bus.i_rdata, x_rdata);
      end
      if (x_rv == 1) begin
        check("rnd/d_err", bus.d_err, x_err);
        check("rnd/d_rdata", bus.d_rdata, x_rdata);
      end
      check("rnd/m_req", bus.m_req, busy);
      if (busy) begin
        check("rnd/mem_sel", bus.mem_sel, (own == 0) ? 2'b00 : 2'b01);
        check("rnd/m_fields", {bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata},
              {t_we, t_be, t_addr, t_wdata});
      end else begin
        check("rnd/mem_sel_idle", bus.mem_sel, 2'b10);
      end
      // Requesters drop req once granted and may then start a new access
      if (x_gnt >= 0) pend[x_gnt] = 1'b0;
      x_gnt = -1;
      x_rv  = -1;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pend[r]    = 1'b1;
          p_addr[r]  = $urandom;
          p_wdata[r] = $urandom;
          p_be[r]    = 4'($urandom_range(0, 15));
          p_we[r]    = 1'($urandom_range(0, 1));
        end
      end
      mdata     = $urandom;
      busy_next = busy;
      ready     = 1'b0;
      if (busy) begin
        mcyc++;
        ready = (mcyc == lat + 1);
        if (ready) begin
          x_rv = own; x_err = 1'b0; x_rdata = mdata; busy_next = 1'b0;
        end else if (mcyc == TIMEOUT) begin
          x_rv = own; x_err = 1'b1; x_rdata = '0; busy_next = 1'b0;
        end
      end else begin
        // m_ready outside a transaction must be ignored
        ready = 1'($urandom_range(0, 1));
        if (pend[0] || pend[1]) begin
          own   = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
          last  = own;
          x_gnt = own;
          busy_next = 1'b1;
          mcyc  = 0;
          lat   = $urandom_range(0, 20);
          if (own == 0) begin
            t_addr = p_addr[0]; t_we = 1'b0; t_be = 4'hF; t_wdata = '0;
          end else begin
            t_addr = p_addr[1]; t_we = p_we[1]; t_be = p_be[1]; t_wdata = p_wdata[1];
          end
        end
      end
      busy = busy_next;
      bus.i_req   = pend[0];
      bus.i_addr  = p_addr[0];
      bus.d_req   = pend[1];
      bus.d_we    = p_we[1];
      bus.d_be    = p_be[1];
      bus.d_addr  = p_addr[1];
      bus.d_wdata = p_wdata[1];
      bus.m_ready = ready;
      bus.m_rdata = mdata;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mc;
    int own;
    vecs[0] = '{is_d: 0, we: 0, addr: 32'h0000_0100, be: 4'h0, wdata: 32'h0, lat: 0,
                mrdata: 32'h0000_0013, x_sel: 2'b00, x_we: 0, x_be: 4'hF, x_wdata: 32'h0,
                x_mcycles: 1, x_err: 0, x_rdata: 32'h0000_0013};
    vecs[1] = '{is_d: 1, we: 1, addr: 32'h0000_2000, be: 4'b0011, wdata: 32'hDEAD_BEEF,
                lat: 3, mrdata: 32'h0000_0055, x_sel: 2'b01, x_we: 1, x_be: 4'b0011,
                x_wdata: 32'hDEAD_BEEF, x_mcycles: 4, x_err: 0, x_rdata: 32'h0000_0055};
    vecs[2] = '{is_d: 1, we: 0, addr: 32'h0000_3000, be: 4'hF, wdata: 32'h1111_1111,
                lat: 20, mrdata: 32'h0000_AAAA, x_sel: 2'b01, x_we: 0, x_be: 4'hF,
                x_wdata: 32'h1111_1111, x_mcycles: 16, x_err: 1, x_rdata: 32'h0};
    vecs[3] = '{is_d: 0, we: 0, addr: 32'h0000_0104, be: 4'h0, wdata: 32'h0, lat: 15,
                mrdata: 32'h0000_1234, x_sel: 2'b00, x_we: 0, x_be: 4'hF, x_wdata: 32'h0,
                x_mcycles: 16, x_err: 0, x_rdata: 32'h0000_1234};
    vecs[4] = '{is_d: 1, we: 1, addr: 32'h0000_5008, be: 4'b1000, wdata: 32'hCAFE_F00D,
                lat: 14, mrdata: 32'h0000_0099, x_sel: 2'b01, x_we: 1, x_be: 4'b1000,
                x_wdata: 32'hCAFE_F00D, x_mcycles: 15, x_err: 0, x_rdata: 32'h0000_0099};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check_reset_outputs("idle");

    // Reset while a data access is in flight
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
    bus.d_addr = 32'h44; bus.d_wdata = 32'h1234_5678;
    step();
    check("rstbusy/d_gnt", bus.d_gnt, 1);
    check("rstbusy/m_req", bus.m_req, 1);
    check("rstbusy/mem_sel", bus.mem_sel, 2'b01);
    bus.d_req = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("rstbusy/async_m_req", bus.m_req, 0);
    check("rstbusy/async_mem_sel", bus.mem_sel, 2'b10);
    check("rstbusy/async_m_addr", bus.m_addr, 0);
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("rstbusy_after");

    // Both requesters held from reset: I, D, I, D with idle cycles between
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_be = 4'hF;
    bus.m_ready = 1'b1; bus.m_rdata = 32'h77;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      own = (k / 2) % 2;
      if (k % 2 == 0) begin
        check("rr/i_gnt", bus.i_gnt, own == 0);
        check("rr/d_gnt", bus.d_gnt, own == 1);
        check("rr/mem_sel", bus.mem_sel, (own == 0) ? 2'b00 : 2'b01);
        check("rr/m_addr", bus.m_addr, (own == 0) ? 32'h10 : 32'h20);
      end else begin
        check("rr/gnt_gap", {bus.i_gnt, bus.d_gnt}, 0);
        check("rr/mem_sel_gap", bus.mem_sel, 2'b10);
        check("rr/i_rvalid", bus.i_rvalid, own == 0);
        check("rr/d_rvalid", bus.d_rvalid, own == 1);
      end
      if (k == 7) idle_inputs();
    end
    step();
    check("rr/drained", bus.m_req, 0);

    // Table of single accesses
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Timeout on a data read while fetch waits, then fetch is granted
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6000; bus.d_be = 4'hF;
    step();
    check("to/d_gnt", bus.d_gnt, 1);
    bus.d_req = 1'b0;
    mc = 0;
    while (bus.m_req === 1'b1 && mc < 40) begin
      mc++;
      if (mc == 2) begin
        bus.i_req = 1'b1; bus.i_addr = 32'h180;
      end
      check("to/i_gnt_blocked", bus.i_gnt, 0);
      step();
    end
    check("to/m_req_cycles", mc, TIMEOUT);
    check("to/d_rvalid", bus.d_rvalid, 1);
    check("to/d_err", bus.d_err, 1);
    check("to/d_rdata", bus.d_rdata, 0);
    check("to/i_rvalid", bus.i_rvalid, 0);
    step();
    check("to/i_gnt", bus.i_gnt, 1);
    check("to/mem_sel", bus.mem_sel, 2'b00);
    check("to/m_addr", bus.m_addr, 32'h180);
    bus.i_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h5A;
    step();
    check("to/i_rvalid", bus.i_rvalid, 1);
    check("to/i_rdata", bus.i_rdata, 32'h5A);
    check("to/i_err", bus.i_err, 0);
    check("to/d_rvalid_quiet", bus.d_rvalid, 0);
    idle_inputs();
    step();

    // Randomized run from a fresh reset so the model's round-robin history matches
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
